// File: rtl/data_ram_if.sv
// Request/response bus between the memory stage and data_ram.
// The memory stage drives a request; data_ram answers with one ready_o strobe.
interface data_ram_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output ce_i, we_i, addr_i, data_i, sel_i,
        input  data_o, ready_o, err_o, busy_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, data_i, sel_i,
        output data_o, ready_o, err_o, busy_o
    );
endinterface

// File: rtl/data_ram.sv
// Single-port word RAM with byte-lane writes and a fixed response latency.
// One request in flight at a time; ready_o strobes LATENCY cycles after acceptance.
module data_ram #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    data_ram_if.slave  bus
);
    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               accept_c;

    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;
    logic [3:0]         sel_q;

    logic               req_we_c;
    logic [31:0]        req_addr_c;
    logic [31:0]        req_data_c;
    logic [3:0]         req_sel_c;
    logic [31:0]        word_addr_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic               in_range_c;
    logic               enter_resp_c;
    logic               wr_en_c;
    logic               rd_en_c;

    logic [31:0]        mem [WORDS];

    // State and latency counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ce_i) begin
                    accept_c   = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request capture
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            sel_q  <= '0;
        end else if (accept_c) begin
            we_q   <= bus.we_i;
            addr_q <= bus.addr_i;
            data_q <= bus.data_i;
            sel_q  <= bus.sel_i;
        end
    end

    // With LATENCY=1 the request enters RESP on its acceptance edge, so use the live inputs
    always_comb begin
        req_we_c   = (state == IDLE) ? bus.we_i   : we_q;
        req_addr_c = (state == IDLE) ? bus.addr_i : addr_q;
        req_data_c = (state == IDLE) ? bus.data_i : data_q;
        req_sel_c  = (state == IDLE) ? bus.sel_i  : sel_q;
    end

    assign word_addr_c  = req_addr_c >> 2;
    assign idx_c        = word_addr_c[DEPTH_LOG2-1:0];
    assign in_range_c   = (word_addr_c >> DEPTH_LOG2) == 32'd0;
    assign enter_resp_c = (next_state == RESP) && (state != RESP);
    assign wr_en_c      = rst_n_i && enter_resp_c && req_we_c && in_range_c;
    assign rd_en_c      = enter_resp_c && !req_we_c && in_range_c;

    // Storage is not reset; byte lanes written on the edge entering RESP
    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel_c[b]) mem[idx_c][8*b +: 8] <= req_data_c[8*b +: 8];
            end
        end
    end

    // Registered response outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.data_o  <= '0;
            bus.ready_o <= 1'b0;
            bus.err_o   <= 1'b0;
            bus.busy_o  <= 1'b0;
        end else begin
            bus.ready_o <= enter_resp_c;
            bus.err_o   <= enter_resp_c && !in_range_c;
            bus.busy_o  <= (next_state != IDLE);
            if (rd_en_c) begin
                bus.data_o <= mem[idx_c];
            end else if (enter_resp_c && !req_we_c) begin
                bus.data_o <= '0;
            end
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram (LATENCY=2, DEPTH_LOG2=10).
// Stimulus pushes expected responses; a negedge monitor pops and checks each ready_o.
module tb_data_ram;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    data_ram_if bus();

    data_ram #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ready_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: ready_o=1 at cycle %0d, no response expected", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks += 2;
                    if (cyc != e.c) begin
                        errors++;
                        $display("FAIL latency: ready at cycle %0d, expected cycle %0d", cyc, e.c);
                    end
                    if (bus.data_o !== e.d) begin
                        errors++;
                        $display("FAIL data_o: got %h, expected %h", bus.data_o, e.d);
                    end
                    if (bus.err_o !== e.e) begin
                        errors++;
                        $display("FAIL err_o: got %b, expected %b", bus.err_o, e.e);
                    end
                end
            end else if (bus.err_o) begin
                checks++;
                errors++;
                $display("FAIL stray_err: err_o=1 without ready_o at cycle %0d", cyc);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        @(negedge clk);
        bus.ce_i   = 1'b1;
        bus.we_i   = we;
        bus.addr_i = a;
        bus.data_i = d;
        bus.sel_i  = s;
        @(posedge clk);
        #1;
        e.d = exp_d;
        e.e = exp_e;
        e.c = cyc + LAT - 1;
        q.push_back(e);
        @(negedge clk);
        bus.ce_i = 1'b0;
        wait_drain();
    endtask

    task automatic check_out(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    initial begin
        exp_t e;
        int   c0;
        logic [31:0] rd_addr [3];
        logic [31:0] rd_data [3];

        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.ce_i   = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.sel_i  = '0;

        repeat (2) @(negedge clk);
        check_out("rst_ready", 32'(bus.ready_o), 32'd0);
        check_out("rst_err",   32'(bus.err_o),   32'd0);
        check_out("rst_busy",  32'(bus.busy_o),  32'd0);
        check_out("rst_data",  bus.data_o,       32'd0);
        rst_n = 1'b1;

        // Full-word write then readback
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Single byte-lane merge; low address bits ignored
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0);
        do_req(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 32'hDEADBEEF, 1'b0);
        do_req(1'b0, 32'h21, 32'h0, 4'h0, 32'h1122AA44, 1'b0);

        do_req(1'b1, 32'h0, 32'h00000001, 4'hF, 32'h1122AA44, 1'b0);
        do_req(1'b1, 32'h4, 32'h00000002, 4'hF, 32'h1122AA44, 1'b0);
        do_req(1'b1, 32'h8, 32'h00000003, 4'hF, 32'h1122AA44, 1'b0);

        // ce_i held high: acceptances every LAT+1 cycles
        rd_addr[0] = 32'h0; rd_addr[1] = 32'h4; rd_addr[2] = 32'h8;
        rd_data[0] = 32'h1; rd_data[1] = 32'h2; rd_data[2] = 32'h3;
        @(negedge clk);
        bus.ce_i   = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = rd_addr[0];
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            e.d = rd_data[i];
            e.e = 1'b0;
            e.c = c0 + i * (LAT + 1) + LAT - 1;
            q.push_back(e);
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            bus.addr_i = rd_addr[i];
            repeat (LAT) @(negedge clk);
        end
        repeat (LAT + 1) @(negedge clk);
        bus.ce_i = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);

        // Out of range: read returns 0, write aliasing word 0 must not land
        do_req(1'b0, 32'h00001000, 32'h0, 4'h0, 32'h0, 1'b1);
        do_req(1'b1, 32'h00001000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'h00000001, 1'b0);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Reset during WAIT aborts the write
        do_req(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        bus.ce_i   = 1'b1;
        bus.we_i   = 1'b1;
        bus.addr_i = 32'h30;
        bus.data_i = 32'h12345678;
        bus.sel_i  = 4'hF;
        @(negedge clk);
        bus.ce_i = 1'b0;
        check_out("wait_busy", 32'(bus.busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("abort_ready", 32'(bus.ready_o), 32'd0);
        check_out("abort_err",   32'(bus.err_o),   32'd0);
        check_out("abort_busy",  32'(bus.busy_o),  32'd0);
        check_out("abort_data",  bus.data_o,       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_req(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

        // Empty lane mask still responds and leaves storage alone
        do_req(1'b1, 32'h40, 32'h55AA55AA, 4'hF, 32'hCAFEF00D, 1'b0);
        do_req(1'b1, 32'h40, 32'h00000000, 4'h0, 32'hCAFEF00D, 1'b0);
        do_req(1'b0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 1'b0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit words stored (1024 words).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to ready_o; legal range 1..15.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low; the block has one clock, and reset is asynchronous and active-low.
REQ-005 ce_i  input  1  chip enable / request valid from the memory stage.
REQ-006 we_i  input  1  1 = write request, 0 = read request; sampled with ce_i.
REQ-007 addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 data_i  input  32  write data, already lane-aligned by the requester.
REQ-009 sel_i  input  4  byte-lane write enables; bit n enables data_i[8n+7:8n].
REQ-010 data_o  output  32  read data word.
REQ-011 ready_o  output  1  one-cycle response strobe.
REQ-012 err_o  output  1  out-of-range strobe, coincident with ready_o.
REQ-013 busy_o  output  1  high from acceptance through the ready_o cycle.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP, with reset state IDLE.
REQ-015 In IDLE with ce_i=1, the block SHALL accept the request at that edge, latch addr_i/we_i/data_i/sel_i, load the latency counter with LATENCY-1 and go to WAIT, or go directly to RESP when LATENCY=1.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL enter RESP on the edge after the counter reads 1.
REQ-017 ready_o SHALL be high only in RESP, for exactly one cycle: a request accepted at edge k gives ready_o high during cycle k+LATENCY.
REQ-018 RESP SHALL always return to IDLE on the next edge; ce_i SHALL be ignored in WAIT and RESP, so the earliest next acceptance is the edge ending RESP+1 (maximum throughput one request per LATENCY+1 cycles).
REQ-019 The word index SHALL be the latched addr[DEPTH_LOG2+1:2]; the request is out of range when latched addr[31:DEPTH_LOG2+2] is nonzero.
REQ-020 Read, in range: data_o SHALL present the full stored word during the RESP cycle and hold it until the next read response.
REQ-021 Write, in range: each byte lane with sel=1 SHALL be updated at the edge entering RESP, and lanes with sel=0 SHALL remain unchanged.
REQ-022 Write with sel=0000 SHALL change no storage but SHALL still produce ready_o.
REQ-023 Write responses SHALL leave data_o unchanged.
REQ-024 Out of range: err_o and ready_o SHALL both pulse, no storage SHALL be written, and a read SHALL drive data_o=0.
REQ-025 A read accepted after a write has responded SHALL return the post-write data; no bypass is required because requests never overlap.
REQ-026 busy_o SHALL equal (state != IDLE).
REQ-027 Storage SHALL be inferable as a single-port synchronous RAM (one read or one write per request).

Reset
REQ-028 While rst_n_i=0, the block SHALL immediately force state=IDLE, counter=0, ready_o=0, err_o=0, busy_o=0 and data_o=0.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the request with no storage write and no ready_o after reset is released.
REQ-031 After rst_n_i deasserts, the first acceptance SHALL occur no earlier than the first rising edge with rst_n_i=1 and ce_i=1.

Verification (LATENCY=2, DEPTH_LOG2=10)
REQ-032 Write 0xDEADBEEF to addr 0x10 with sel=1111, then read 0x10 -> each ready_o comes 2 cycles after acceptance; read returns data_o=0xDEADBEEF, err_o=0.
REQ-033 Word at 0x20 holds 0x11223344; write data_i=0x0000AA00 with sel=0010, then read 0x21 -> data_o=0x1122AA44.
REQ-034 Hold ce_i=1 continuously with reads of 0x0, 0x4 and 0x8 -> acceptances exactly 3 cycles apart, one ready_o pulse each, with no extra pulses.
REQ-035 Read 0x00001000 (index beyond 1023) -> ready_o=1 and err_o=1 in the same cycle, data_o=0; a write to the same address leaves all words unchanged.
REQ-036 Assert rst_n_i=0 mid-cycle during WAIT of a write to 0x30 -> outputs go to 0 immediately with no clock edge, no ready_o follows, and a later read of 0x30 returns the pre-write value.
REQ-037 Write with sel=0000 to 0x40 -> ready_o pulses, and the word at 0x40 is unchanged on readback.
